// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit.
//   fetch_state_t : sequencer states (IDLE, RUN, HALT)
//   NOP_INSTR     : instruction issued in an invalid slot (LSH by 0)
package Definitions;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [8:0] NOP_INSTR = 9'h080;

endpackage

// File: rtl/fetch_unit_branch_eval.sv
// Combinational branch resolution for the fetch unit.
// Ports:
//   slot_valid     in  1  current instruction slot holds a real instruction
//   branch_ez      in  1  branch if operand is zero
//   branch_nz      in  1  branch if operand is non-zero
//   branch_always  in  1  unconditional branch
//   operand        in  W  register value: condition source and target
//   taken          out 1  branch is taken this cycle
//   target         out T  operand zero-extended to the address width
module branch_eval
  import Definitions::*;
#(
  parameter int T = 10,
  parameter int W = 8
) (
  input  logic         slot_valid,
  input  logic         branch_ez,
  input  logic         branch_nz,
  input  logic         branch_always,
  input  logic [W-1:0] operand,
  output logic         taken,
  output logic [T-1:0] target
);

  logic op_zero;

  assign op_zero = (operand == '0);

  // A bubble slot carries no decoded instruction, so its branch bits are ignored.
  assign taken  = slot_valid & (branch_always | (branch_ez & op_zero) | (branch_nz & ~op_zero));
  assign target = T'(operand);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer with a one-cycle synchronous instruction memory.
// Optional feature macro: FETCH_CYCLE_CNT_EN adds a saturating 16-bit
// CycleCount output counting RUN cycles.
// Ports:
//   Clk            in  1   clock, rising edge
//   Reset          in  1   synchronous active-high reset
//   Start          in  1   begin execution at address 0 (ignored in RUN)
//   Done_in        in  1   decoder halt for the current instruction
//   BranchEZ/NZ/Always in 1 decoder branch requests
//   BranchOperand  in  W   branch condition source and target
//   ImemRdata      in  9   instruction memory data (one cycle after ImemAddr)
//   ImemAddr       out T   instruction memory address (fetch register FA)
//   Instruction    out 9   current instruction, NOP_INSTR when slot invalid
//   ProgCtr_p1     out T   ExecPC + 1, link value for JAL
//   Running        out 1   in RUN
//   Done           out 1   in HALT
//   CycleCount     out 16  RUN cycle count (FETCH_CYCLE_CNT_EN only)
//
// state | meaning
// IDLE  | after reset, waiting for Start
// RUN   | fetching/executing; V=0 marks the bubble after a taken branch
// HALT  | decoder signalled done, waiting for Start
module fetch_unit
  import Definitions::*;
#(
  parameter int T = 10,
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Done_in,
  input  logic         BranchEZ,
  input  logic         BranchNZ,
  input  logic         BranchAlways,
  input  logic [W-1:0] BranchOperand,
  input  logic [8:0]   ImemRdata,
  output logic [T-1:0] ImemAddr,
  output logic [8:0]   Instruction,
  output logic [T-1:0] ProgCtr_p1,
  output logic         Running,
`ifdef FETCH_CYCLE_CNT_EN
  output logic         Done,
  output logic [15:0]  CycleCount
`else
  output logic         Done
`endif
);

  fetch_state_t state;
  logic [T-1:0] fa;
  logic [T-1:0] exec_pc;
  logic         v;
  logic         taken;
  logic [T-1:0] target;

  branch_eval #(.T(T), .W(W)) u_branch_eval (
    .slot_valid    (v),
    .branch_ez     (BranchEZ),
    .branch_nz     (BranchNZ),
    .branch_always (BranchAlways),
    .operand       (BranchOperand),
    .taken         (taken),
    .target        (target)
  );

  assign ImemAddr    = fa;
  assign Instruction = v ? ImemRdata : NOP_INSTR;
  assign ProgCtr_p1  = exec_pc + T'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      fa      <= '0;
      exec_pc <= '0;
      v       <= 1'b0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (Start) begin
            // Address 0 is already on ImemAddr, so slot 0 is valid next cycle.
            state   <= RUN;
            exec_pc <= '0;
            fa      <= T'(1);
            v       <= 1'b1;
            Running <= 1'b1;
            Done    <= 1'b0;
          end
        end
        RUN: begin
          if (v && Done_in) begin
            // Halt wins over a branch decoded in the same instruction.
            state   <= HALT;
            fa      <= '0;
            exec_pc <= '0;
            v       <= 1'b0;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (taken) begin
            // Data for FA is already in flight; squash it as one bubble.
            exec_pc <= fa;
            fa      <= target;
            v       <= 1'b0;
          end else begin
            exec_pc <= fa;
            fa      <= fa + T'(1);
            v       <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          fa      <= '0;
          exec_pc <= '0;
          v       <= 1'b0;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CycleCount <= '0;
    end else if ((state == IDLE || state == HALT) && Start) begin
      CycleCount <= '0;
    end else if (state == RUN && CycleCount != 16'hFFFF) begin
      CycleCount <= CycleCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural model tracks which
// instruction address is executing (or whether the slot is a bubble) and
// predicts every output each cycle under directed and random stimulus.
module tb_fetch_unit;

  localparam int T = 10;
  localparam int W = 8;
  localparam int DEPTH = 1 << T;
  localparam logic [8:0] NOP = 9'h080;

  logic         Clk = 1'b0;
  logic         Reset, Start, Done_in, BranchEZ, BranchNZ, BranchAlways;
  logic [W-1:0] BranchOperand;
  logic [8:0]   ImemRdata = '0;
  logic [T-1:0] ImemAddr;
  logic [8:0]   Instruction;
  logic [T-1:0] ProgCtr_p1;
  logic         Running, Done;
`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0]  CycleCount;
`endif

  fetch_unit #(.T(T), .W(W)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Start         (Start),
    .Done_in       (Done_in),
    .BranchEZ      (BranchEZ),
    .BranchNZ      (BranchNZ),
    .BranchAlways  (BranchAlways),
    .BranchOperand (BranchOperand),
    .ImemRdata     (ImemRdata),
    .ImemAddr      (ImemAddr),
    .Instruction   (Instruction),
    .ProgCtr_p1    (ProgCtr_p1),
    .Running       (Running),
`ifdef FETCH_CYCLE_CNT_EN
    .Done          (Done),
    .CycleCount    (CycleCount)
`else
    .Done          (Done)
`endif
  );

  always #5 Clk = ~Clk;

  logic [8:0] rom [DEPTH];
  always @(posedge Clk) ImemRdata <= rom[ImemAddr];

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 idle, 1 run, 2 halt. In run, either address m_pc is
  // executing, or m_bubble says the slot after a taken branch at m_pc.
  int m_mode   = 0;
  int m_pc     = 0;
  int m_tgt    = 0;
  bit m_bubble = 0;
  int m_cnt    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [8:0]  e_instr;
    int          e_addr, e_p1;
    if (m_mode == 1 && !m_bubble) begin
      e_instr = rom[m_pc];
      e_addr  = (m_pc + 1) % DEPTH;
      e_p1    = (m_pc + 1) % DEPTH;
    end else if (m_mode == 1) begin
      e_instr = NOP;
      e_addr  = m_tgt;
      e_p1    = (m_pc + 2) % DEPTH;
    end else begin
      e_instr = NOP;
      e_addr  = 0;
      e_p1    = 1;
    end
    check_eq("instruction", 32'(Instruction), 32'(e_instr));
    check_eq("imem_addr",   32'(ImemAddr),    32'(e_addr));
    check_eq("prog_ctr_p1", 32'(ProgCtr_p1),  32'(e_p1));
    check_eq("running",     32'(Running),     32'(m_mode == 1));
    check_eq("done",        32'(Done),        32'(m_mode == 2));
`ifdef FETCH_CYCLE_CNT_EN
    check_eq("cycle_count", 32'(CycleCount),  32'(m_cnt));
`endif
  endtask

  task automatic model_advance(input bit rst, st, dn, ez, nz, al, input int op);
    if (rst) begin
      m_mode = 0; m_bubble = 0; m_cnt = 0;
    end else if (m_mode != 1) begin
      if (st) begin
        m_mode = 1; m_pc = 0; m_bubble = 0; m_cnt = 0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt++;
      if (m_bubble) begin
        m_bubble = 0;
        m_pc = m_tgt;
      end else if (dn) begin
        m_mode = 2;
      end else if (al || (ez && op == 0) || (nz && op != 0)) begin
        m_bubble = 1;
        m_tgt = op;
      end else begin
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic step(input bit rst, st, dn, ez, nz, al, input int op);
    Reset = rst; Start = st; Done_in = dn;
    BranchEZ = ez; BranchNZ = nz; BranchAlways = al;
    BranchOperand = W'(op);
    model_advance(rst, st, dn, ez, nz, al, op);
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = 9'($urandom);
      if (rom[i] == NOP) rom[i] = 9'h1A5;
    end
    rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[3] = 9'h044;

    // Reset, then sequential fetch of 0..3; Start while held in reset is ignored.
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);          // pc 0
    idle_steps(2);                      // pc 1, 2
    step(0, 0, 0, 0, 0, 1, 8'h40);      // branch at pc 2 -> bubble
    step(0, 0, 0, 0, 0, 0, 0);          // pc 64
    // Conditional branches: taken cases produce a bubble.
    step(0, 0, 0, 1, 0, 0, 0);          // EZ op 0 taken -> bubble
    step(0, 0, 0, 0, 0, 0, 0);          // pc 0
    step(0, 1, 0, 1, 0, 0, 5);          // EZ op 5 not taken, Start ignored -> pc 1
    step(0, 0, 0, 0, 1, 0, 0);          // NZ op 0 not taken -> pc 2
    step(0, 0, 0, 0, 1, 0, 5);          // NZ op 5 taken -> bubble
    step(0, 0, 1, 1, 1, 1, 9);          // halt/branch ignored in bubble -> pc 5
    step(0, 0, 0, 0, 0, 1, 3);          // -> bubble
    step(0, 0, 0, 0, 0, 0, 0);          // pc 3
    step(0, 0, 1, 0, 0, 1, 8'h20);      // halt beats branch -> HALT
    idle_steps(2);
    step(0, 1, 0, 0, 0, 0, 0);          // restart: pc 0
    idle_steps(2);

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      bit rst, st, dn, ez, nz, al;
      int op;
      rst = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 5) == 0);
      dn  = ($urandom_range(0, 24) == 0);
      ez  = ($urandom_range(0, 4) == 0);
      nz  = ($urandom_range(0, 4) == 0);
      al  = ($urandom_range(0, 7) == 0);
      op  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      step(rst, st, dn, ez, nz, al, op);
    end

    // Straight-line run across the top of the address space.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle_steps(DEPTH + 2);

    // Reset during a branch bubble.
    step(0, 0, 0, 0, 0, 1, 8'h10);
    step(1, 0, 0, 0, 0, 0, 0);
    check_eq("reset_in_bubble_instr", 32'(Instruction), 32'(NOP));
    idle_steps(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter T, default 10, program-counter and instruction-address width.
REQ-002 Parameter W, default 8, datapath width of BranchOperand.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  single-cycle request to begin execution at address 0.
REQ-006 Done_in  input  1  decoder halt indication for the current Instruction.
REQ-007 BranchEZ, BranchNZ, BranchAlways  input  1 each  decoder branch requests for the current Instruction.
REQ-008 BranchOperand  input  W  register value read by the branch; condition source and target.
REQ-009 ImemRdata  input  9  synchronous instruction-memory data, valid one cycle after ImemAddr.
REQ-010 ImemAddr  output  T  instruction-memory read address, driven directly from fetch register FA.
REQ-011 Instruction  output  9  instruction to the decoder; NOP_INSTR when the slot is invalid.
REQ-012 ProgCtr_p1  output  T  (ExecPC + 1) mod 2^T, link value for JAL.
REQ-013 Running  output  1  high while in RUN.
REQ-014 Done  output  1  high while in HALT.

Function
REQ-015 States IDLE, RUN, HALT; registers FA (T), ExecPC (T), V (1).
REQ-016 Instruction SHALL equal ImemRdata when V=1, else NOP_INSTR (9'h080, LSH by 0).
REQ-017 IDLE/HALT with Start=1: next state RUN, ExecPC<=0, FA<=1, V<=1, Done<=0; first valid Instruction one cycle after Start.
REQ-018 Start SHALL be ignored in RUN.
REQ-019 Taken = V & (BranchAlways | (BranchEZ & BranchOperand==0) | (BranchNZ & BranchOperand!=0)).
REQ-020 Branch target SHALL be BranchOperand zero-extended to T bits.
REQ-021 RUN, not taken, no halt: ExecPC<=FA, FA<=FA+1 (wraps 2^T-1 to 0), V<=1.
REQ-022 RUN, taken: ExecPC<=FA, FA<=target, V<=0; exactly one NOP bubble, then Instruction=mem[target] with ExecPC=target.
REQ-023 RUN, V=1 and Done_in=1: next state HALT, V<=0, FA<=0, ExecPC<=0; Done_in SHALL take priority over any simultaneous branch.
REQ-024 Done_in and branch inputs SHALL be ignored while V=0.
REQ-025 In IDLE and HALT, FA=0, V=0, ImemAddr=0.

Reset
REQ-026 Reset SHALL force IDLE, FA=0, ExecPC=0, V=0, Done=0, Running=0, Instruction=NOP_INSTR, from any state including mid-branch bubble.
REQ-027 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-028 Macro FETCH_CYCLE_CNT_EN defined: adds output CycleCount (16 bits), cleared on accepted Start and Reset, +1 every RUN cycle, saturates at 16'hFFFF, holds in HALT.
REQ-029 Macro FETCH_CYCLE_CNT_EN undefined: CycleCount port and counter logic absent; all other behaviour identical.

Structure
REQ-030 Package Definitions SHALL hold the fetch_state_t enum (IDLE, RUN, HALT) and the NOP_INSTR constant.
REQ-031 Taken/target evaluation SHALL live in a combinational sub-module branch_eval.

Verification
REQ-032 Reset, Start, ROM[0..3]=distinct words -> Instruction ROM[0],ROM[1],ROM[2],ROM[3] on cycles 1-4; ProgCtr_p1 1,2,3,4.
REQ-033 BranchAlways at ExecPC=2, BranchOperand=8'h40 -> next cycle NOP 9'h080, then ROM[64] with ExecPC=64.
REQ-034 BranchEZ with operand 0 taken, with operand 5 not taken; BranchNZ the inverse -> bubble only on the taken cases.
REQ-035 Done_in with BranchAlways at ExecPC=3 -> HALT, Done=1, ImemAddr=0; second Start -> ROM[0] again, Done=0.
REQ-036 Run straight to FA=1023 -> FA wraps to 0, ProgCtr_p1 at ExecPC=1023 equals 0.
REQ-037 Reset asserted during branch bubble -> IDLE, Instruction=NOP; with FETCH_CYCLE_CNT_EN, CycleCount=0.
